// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the two-requester register-file arbiter.
package regfile_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } state_t;

   localparam logic OWN_R0 = 1'b0;
   localparam logic OWN_R1 = 1'b1;

   localparam int CNT_W = 4;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// One requester channel into the arbiter: request/command in, grant and read completion out.
interface regfile_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  req;
   logic                  wr;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  gnt;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  err;

   modport master (
      output req, wr, addr, wdata,
      input  gnt, rdata, rvalid, err
   );

   modport slave (
      input  req, wr, addr, wdata,
      output gnt, rdata, rvalid, err
   );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the one not served last.
module rr_pick2
   import regfile_arb_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last,
   output logic o_valid,
   output logic o_owner
);

   assign o_valid = i_req0 | i_req1;
   assign o_owner = (i_req0 & i_req1) ? ~i_last
                  : (i_req1 ? OWN_R1 : OWN_R0);

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the single Reg_File access port between two requesters, routes read data back
// to the owner of each access and flags reads the register file never answers.
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int RD_TIMEOUT = 7
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   regfile_arbiter_if.slave      req0_if,
   regfile_arbiter_if.slave      req1_if,
   output logic                  o_rf_wr_en,
   output logic                  o_rf_rd_en,
   output logic [ADDR_WIDTH-1:0] o_rf_addr,
   output logic [DATA_WIDTH-1:0] o_rf_wr_data,
   input  logic [DATA_WIDTH-1:0] i_rf_rd_data,
   input  logic                  i_rf_rd_valid
);

   localparam cnt_t TIMEOUT_CNT = cnt_t'(RD_TIMEOUT);

   state_t                      r_state,      w_state_nxt;
   logic                        r_last,       w_last_nxt;
   logic                        r_owner,      w_owner_nxt;
   logic                        r_wr,         w_wr_nxt;
   cnt_t                        r_cnt,        w_cnt_nxt;
   logic [1:0]                  r_gnt,        w_gnt_nxt;
   logic                        r_rf_wr_en,   w_rf_wr_en_nxt;
   logic                        r_rf_rd_en,   w_rf_rd_en_nxt;
   logic [ADDR_WIDTH-1:0]       r_rf_addr,    w_rf_addr_nxt;
   logic [DATA_WIDTH-1:0]       r_rf_wr_data, w_rf_wr_data_nxt;
   logic [1:0][DATA_WIDTH-1:0]  r_rdata,      w_rdata_nxt;
   logic [1:0]                  r_rvalid,     w_rvalid_nxt;
   logic [1:0]                  r_err,        w_err_nxt;

   logic                        w_pick_valid;
   logic                        w_pick_owner;
   logic                        w_sel_wr;
   logic [ADDR_WIDTH-1:0]       w_sel_addr;
   logic [DATA_WIDTH-1:0]       w_sel_wdata;

   rr_pick2 u_pick (
      .i_req0  (req0_if.req),
      .i_req1  (req1_if.req),
      .i_last  (r_last),
      .o_valid (w_pick_valid),
      .o_owner (w_pick_owner)
   );

   assign w_sel_wr    = w_pick_owner ? req1_if.wr    : req0_if.wr;
   assign w_sel_addr  = w_pick_owner ? req1_if.addr  : req0_if.addr;
   assign w_sel_wdata = w_pick_owner ? req1_if.wdata : req0_if.wdata;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned,
      // which would otherwise infer a latch.
      w_state_nxt      = r_state;
      w_last_nxt       = r_last;
      w_owner_nxt      = r_owner;
      w_wr_nxt         = r_wr;
      w_cnt_nxt        = r_cnt;
      w_gnt_nxt        = '0;
      w_rf_wr_en_nxt   = 1'b0;
      w_rf_rd_en_nxt   = 1'b0;
      w_rf_addr_nxt    = r_rf_addr;
      w_rf_wr_data_nxt = r_rf_wr_data;
      w_rdata_nxt      = r_rdata;
      w_rvalid_nxt     = '0;
      w_err_nxt        = '0;

      case (r_state)
         IDLE: begin
            // Outputs for the ISSUE cycle are loaded here so they come straight from flops.
            if (w_pick_valid) begin
               w_state_nxt             = ISSUE;
               w_last_nxt              = w_pick_owner;
               w_owner_nxt             = w_pick_owner;
               w_wr_nxt                = w_sel_wr;
               w_gnt_nxt[w_pick_owner] = 1'b1;
               w_rf_addr_nxt           = w_sel_addr;
               if (w_sel_wr) begin
                  w_rf_wr_en_nxt   = 1'b1;
                  w_rf_wr_data_nxt = w_sel_wdata;
               end else begin
                  w_rf_rd_en_nxt   = 1'b1;
               end
            end
         end

         ISSUE: begin
            if (r_wr) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = WAIT_RD;
               w_cnt_nxt   = '0;
            end
         end

         WAIT_RD: begin
            // Valid is tested first so a response on the last allowed cycle still completes.
            if (i_rf_rd_valid) begin
               w_rdata_nxt[r_owner]  = i_rf_rd_data;
               w_rvalid_nxt[r_owner] = 1'b1;
               w_state_nxt           = IDLE;
            end else if (r_cnt == TIMEOUT_CNT) begin
               w_rdata_nxt[r_owner]  = '0;
               w_err_nxt[r_owner]    = 1'b1;
               w_state_nxt           = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + cnt_t'(1);
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples the
      // pre-edge values, independent of statement order.
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_last       <= OWN_R1;
         r_owner      <= OWN_R0;
         r_wr         <= 1'b0;
         r_cnt        <= '0;
         r_gnt        <= '0;
         r_rf_wr_en   <= 1'b0;
         r_rf_rd_en   <= 1'b0;
         r_rf_addr    <= '0;
         r_rf_wr_data <= '0;
         r_rdata      <= '0;
         r_rvalid     <= '0;
         r_err        <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_last       <= w_last_nxt;
         r_owner      <= w_owner_nxt;
         r_wr         <= w_wr_nxt;
         r_cnt        <= w_cnt_nxt;
         r_gnt        <= w_gnt_nxt;
         r_rf_wr_en   <= w_rf_wr_en_nxt;
         r_rf_rd_en   <= w_rf_rd_en_nxt;
         r_rf_addr    <= w_rf_addr_nxt;
         r_rf_wr_data <= w_rf_wr_data_nxt;
         r_rdata      <= w_rdata_nxt;
         r_rvalid     <= w_rvalid_nxt;
         r_err        <= w_err_nxt;
      end
   end

   assign req0_if.gnt    = r_gnt[0];
   assign req0_if.rdata  = r_rdata[0];
   assign req0_if.rvalid = r_rvalid[0];
   assign req0_if.err    = r_err[0];

   assign req1_if.gnt    = r_gnt[1];
   assign req1_if.rdata  = r_rdata[1];
   assign req1_if.rvalid = r_rvalid[1];
   assign req1_if.err    = r_err[1];

   assign o_rf_wr_en   = r_rf_wr_en;
   assign o_rf_rd_en   = r_rf_rd_en;
   assign o_rf_addr    = r_rf_addr;
   assign o_rf_wr_data = r_rf_wr_data;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: writes, alternating reads, timeout, reset mid-read,
// stray valids and the valid/timeout tie, against a one-cycle-latency Reg_File model.
module tb_regfile_arbiter;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 7;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          rf_wr_en;
   logic          rf_rd_en;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_wr_data;
   logic [DW-1:0] rf_rd_data  = '0;
   logic          rf_rd_valid = 1'b0;

   logic          mute        = 1'b0;
   logic          force_valid = 1'b0;
   logic [DW-1:0] force_data  = '0;

   int n_checks = 0;
   int n_errors = 0;

   regfile_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r0_if ();
   regfile_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r1_if ();

   always #5 clk = ~clk;

   regfile_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RD_TIMEOUT (TO)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .req0_if       (r0_if),
      .req1_if       (r1_if),
      .o_rf_wr_en    (rf_wr_en),
      .o_rf_rd_en    (rf_rd_en),
      .o_rf_addr     (rf_addr),
      .o_rf_wr_data  (rf_wr_data),
      .i_rf_rd_data  (rf_rd_data),
      .i_rf_rd_valid (rf_rd_valid)
   );

   function automatic logic [DW-1:0] rf_contents(input logic [AW-1:0] a);
      case (a)
         4'h2:    return 8'h81;
         4'h3:    return 8'h0D;
         default: return {a, ~a};
      endcase
   endfunction

   // Reg_File model: one-cycle read latency; mute withholds valid, force_valid injects one.
   always @(posedge clk) begin
      rf_rd_valid <= (rf_rd_en && !mute) || force_valid;
      rf_rd_data  <= force_valid ? force_data : rf_contents(rf_addr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called in an IDLE cycle with the requests already driven; returns in the RVALID cycle.
   task automatic read_round(input logic owner, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      tick();
      check("rd_gnt0", r0_if.gnt, owner == 1'b0);
      check("rd_gnt1", r1_if.gnt, owner == 1'b1);
      check("rd_rf_rd_en", rf_rd_en, 1);
      check("rd_rf_addr", rf_addr, addr);
      if (owner) r1_if.req = 1'b0; else r0_if.req = 1'b0;
      tick();
      check("rd_early_rvalid", {r1_if.rvalid, r0_if.rvalid}, 0);
      if (owner) r1_if.req = 1'b1; else r0_if.req = 1'b1;
      tick();
      if (owner) begin
         check("rd_rvalid1", r1_if.rvalid, 1);
         check("rd_rdata1", r1_if.rdata, data);
         check("rd_rvalid0_quiet", r0_if.rvalid, 0);
      end else begin
         check("rd_rvalid0", r0_if.rvalid, 1);
         check("rd_rdata0", r0_if.rdata, data);
         check("rd_rvalid1_quiet", r1_if.rvalid, 0);
      end
      check("rd_no_err", {r1_if.err, r0_if.err}, 0);
   endtask

   initial begin
      r0_if.req = 1'b0; r0_if.wr = 1'b0; r0_if.addr = '0; r0_if.wdata = '0;
      r1_if.req = 1'b0; r1_if.wr = 1'b0; r1_if.addr = '0; r1_if.wdata = '0;

      // Reset state
      tick(); tick();
      check("rst_gnt", {r1_if.gnt, r0_if.gnt}, 0);
      check("rst_strobes", {rf_wr_en, rf_rd_en}, 0);
      check("rst_rf_addr", rf_addr, 0);
      check("rst_rf_wr_data", rf_wr_data, 0);
      check("rst_rvalid_err", {r1_if.rvalid, r0_if.rvalid, r1_if.err, r0_if.err}, 0);
      check("rst_rdata", {r1_if.rdata, r0_if.rdata}, 0);
      rst_n = 1'b1;
      tick();

      // Write from requester 0
      r0_if.wr = 1'b1; r0_if.addr = 4'h5; r0_if.wdata = 8'hA5; r0_if.req = 1'b1;
      tick();
      check("wr_gnt0", r0_if.gnt, 1);
      check("wr_gnt1", r1_if.gnt, 0);
      check("wr_rf_wr_en", rf_wr_en, 1);
      check("wr_rf_rd_en", rf_rd_en, 0);
      check("wr_rf_addr", rf_addr, 4'h5);
      check("wr_rf_wr_data", rf_wr_data, 8'hA5);
      r0_if.req = 1'b0;
      tick();
      check("wr_gnt_done", {r1_if.gnt, r0_if.gnt}, 0);
      check("wr_strobe_done", rf_wr_en, 0);
      check("wr_addr_hold", rf_addr, 4'h5);
      check("wr_data_hold", rf_wr_data, 8'hA5);
      r1_if.wr = 1'b1; r1_if.addr = 4'h6; r1_if.wdata = 8'h5A; r1_if.req = 1'b1;
      tick();
      check("wr2_gnt1", r1_if.gnt, 1);
      check("wr2_rf_wr_data", rf_wr_data, 8'h5A);
      r1_if.req = 1'b0;
      tick();

      // Simultaneous reads after a fresh reset: strict 0,1,0,1 alternation
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      r0_if.wr = 1'b0; r0_if.addr = 4'h2;
      r1_if.wr = 1'b0; r1_if.addr = 4'h3;
      r0_if.req = 1'b1; r1_if.req = 1'b1;
      read_round(1'b0, 4'h2, 8'h81);
      read_round(1'b1, 4'h3, 8'h0D);
      check("alt_rdata0_hold", r0_if.rdata, 8'h81);
      read_round(1'b0, 4'h2, 8'h81);
      read_round(1'b1, 4'h3, 8'h0D);
      r0_if.req = 1'b0; r1_if.req = 1'b0;
      tick();
      check("alt_quiet", {r1_if.gnt, r0_if.gnt, r1_if.rvalid, r0_if.rvalid}, 0);

      // Read timeout on requester 1
      mute = 1'b1;
      r1_if.addr = 4'h7; r1_if.req = 1'b1;
      tick();
      check("to_gnt1", r1_if.gnt, 1);
      r1_if.req = 1'b0;
      tick();
      for (int i = 0; i <= TO; i++) begin
         check("to_err_early", r1_if.err, 0);
         check("to_rvalid_early", r1_if.rvalid, 0);
         tick();
      end
      check("to_err1", r1_if.err, 1);
      check("to_rdata1", r1_if.rdata, 0);
      check("to_rvalid1", r1_if.rvalid, 0);
      check("to_err0", r0_if.err, 0);
      mute = 1'b0;
      r0_if.addr = 4'h2; r0_if.req = 1'b1;
      tick();
      check("to_err1_once", r1_if.err, 0);
      check("to_next_gnt0", r0_if.gnt, 1);
      r0_if.req = 1'b0;
      tick(); tick();
      check("to_next_rvalid0", r0_if.rvalid, 1);
      check("to_next_rdata0", r0_if.rdata, 8'h81);

      // Reset while waiting for read data
      mute = 1'b1;
      r0_if.addr = 4'h3; r0_if.req = 1'b1;
      tick();
      r0_if.req = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      check("mrst_gnt", {r1_if.gnt, r0_if.gnt}, 0);
      check("mrst_strobes", {rf_wr_en, rf_rd_en}, 0);
      check("mrst_rf_addr", rf_addr, 0);
      check("mrst_rf_wr_data", rf_wr_data, 0);
      check("mrst_rvalid_err", {r1_if.rvalid, r0_if.rvalid, r1_if.err, r0_if.err}, 0);
      check("mrst_rdata", {r1_if.rdata, r0_if.rdata}, 0);
      rst_n = 1'b1;
      mute = 1'b0;
      force_valid = 1'b1; force_data = 8'h55;
      tick();
      force_valid = 1'b0;
      check("mrst_no_rvalid_a", {r1_if.rvalid, r0_if.rvalid}, 0);
      tick();
      check("mrst_no_rvalid_b", {r1_if.rvalid, r0_if.rvalid}, 0);
      check("mrst_no_err", {r1_if.err, r0_if.err}, 0);
      check("mrst_rdata0_zero", r0_if.rdata, 0);
      r0_if.addr = 4'h2; r1_if.addr = 4'h3;
      r0_if.req = 1'b1; r1_if.req = 1'b1;
      read_round(1'b0, 4'h2, 8'h81);
      read_round(1'b1, 4'h3, 8'h0D);
      r0_if.req = 1'b0; r1_if.req = 1'b0;
      tick();

      // Stray valid in IDLE and during a write ISSUE
      force_valid = 1'b1; force_data = 8'hEE;
      tick();
      force_valid = 1'b0;
      tick();
      check("stray_idle_rvalid", {r1_if.rvalid, r0_if.rvalid}, 0);
      check("stray_idle_rdata0", r0_if.rdata, 8'h81);
      check("stray_idle_rdata1", r1_if.rdata, 8'h0D);
      r0_if.wr = 1'b1; r0_if.addr = 4'h9; r0_if.wdata = 8'h77; r0_if.req = 1'b1;
      force_valid = 1'b1;
      tick();
      check("stray_wr_gnt0", r0_if.gnt, 1);
      check("stray_wr_en", rf_wr_en, 1);
      force_valid = 1'b0; r0_if.req = 1'b0;
      tick();
      check("stray_wr_rvalid_a", {r1_if.rvalid, r0_if.rvalid}, 0);
      tick();
      check("stray_wr_rvalid_b", {r1_if.rvalid, r0_if.rvalid}, 0);
      check("stray_wr_rdata0", r0_if.rdata, 8'h81);
      check("stray_wr_rdata1", r1_if.rdata, 8'h0D);

      // Valid arriving on the final timeout cycle wins
      mute = 1'b1;
      r0_if.wr = 1'b0; r0_if.addr = 4'h4; r0_if.req = 1'b1;
      tick();
      r0_if.req = 1'b0;
      tick();
      repeat (TO - 1) tick();
      force_valid = 1'b1; force_data = 8'h3C;
      tick();
      force_valid = 1'b0;
      check("tie_no_err_early", r0_if.err, 0);
      check("tie_no_rvalid_early", r0_if.rvalid, 0);
      tick();
      check("tie_rvalid0", r0_if.rvalid, 1);
      check("tie_rdata0", r0_if.rdata, 8'h3C);
      check("tie_no_err", {r1_if.err, r0_if.err}, 0);
      mute = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single register-file access port (WrEn/RdEn/Address/WrData, RdData/RdData_Valid) between the system controller (requester 0) and a second master such as a debug/config loader (requester 1).
- Sits in the REF_CLK domain between the requesters and Reg_File.
- Serialises accesses and routes read data back to the requester that owns the access.
- Detects a register file that never returns RdData_Valid.

Parameters:
- DATA_WIDTH, 8, register data width
- ADDR_WIDTH, 4, register address width
- RD_TIMEOUT, 7, cycles to wait in WAIT_RD for RF_RD_VALID before flagging an error (1..15)

Ports:
- CLK  input  1  REF_CLK domain clock
- RST  input  1  synchronous, active-low reset
- REQ0, REQ1  input  1  access request from requester 0 / 1
- WR0, WR1  input  1  1 = write, 0 = read; held stable while REQn is high
- ADDR0, ADDR1  input  ADDR_WIDTH  register address
- WDATA0, WDATA1  input  DATA_WIDTH  write data
- GNT0, GNT1  output  1  one-cycle accept pulse
- RDATA0, RDATA1  output  DATA_WIDTH  read data, held until the next read completion for that requester
- RVALID0, RVALID1  output  1  one-cycle read-complete pulse
- ERR0, ERR1  output  1  one-cycle read-timeout pulse
- RF_WR_EN  output  1  register file write strobe
- RF_RD_EN  output  1  register file read strobe
- RF_ADDR  output  ADDR_WIDTH  register file address
- RF_WR_DATA  output  DATA_WIDTH  register file write data
- RF_RD_DATA  input  DATA_WIDTH  register file read data
- RF_RD_VALID  input  1  register file read valid

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-low: it is sampled only on the rising CLK edge.
- Reset values: all outputs 0, state IDLE, LAST = 1 (requester 0 wins the first tie), timeout counter 0.
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE state:
  - REQn is sampled only in IDLE.
  - On an edge where at least one REQ is high, the arbiter picks the owner, latches the owner's WR/ADDR/WDATA, sets LAST = owner, and moves to ISSUE.
  - Only REQ0 high: owner = 0. Only REQ1 high: owner = 1. Both high: owner = !LAST.
- ISSUE state (exactly one cycle):
  - GNTowner = 1.
  - RF_ADDR = latched address.
  - Write: RF_WR_EN = 1 and RF_WR_DATA = latched data, then go to IDLE.
  - Read: RF_RD_EN = 1, then go to WAIT_RD with the counter cleared.
- Requester rule:
  - A requester must deassert REQ in the cycle after it sees GNT.
  - REQ still high in the next IDLE cycle counts as a new request.
  - Sustained write throughput is therefore one access per 2 cycles.
- WAIT_RD state:
  - RF_RD_VALID = 1: RDATAowner <= RF_RD_DATA; RVALIDowner = 1 the next cycle; go to IDLE.
  - Otherwise the counter increments.
  - Counter == RD_TIMEOUT with no valid: ERRowner = 1 the next cycle, RDATAowner <= 0, go to IDLE.
  - If valid and timeout coincide, valid wins.
- Read latency: read accepted at edge t -> RF_RD_EN in cycle t+1. With Reg_File 1-cycle latency, RF_RD_VALID arrives in t+2 and RVALID appears in t+3.
- RF_RD_VALID outside WAIT_RD is ignored; no RVALID is generated.
- RF_ADDR and RF_WR_DATA hold their last value when idle. Strobes are 0 outside ISSUE.
- Reset mid-operation: a pending read is abandoned with no RVALID and no ERR. LAST returns to 1. Any REQ held through reset is re-arbitrated from IDLE.
- The arbiter is starvation free: with both REQs continuously re-asserted, grants strictly alternate.

Decomposition:
- Package regfile_arb_pkg:
  - state encoding IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2
  - owner constants OWN_R0 = 1'b0, OWN_R1 = 1'b1
  - timeout counter width 4
- One sub-module, rr_pick2: combinational two-way round-robin pick from (REQ0, REQ1, LAST) producing valid and owner. The FSM, latches and counters stay in regfile_arbiter.

Test Plan:
- Write: REQ0 with WR0 = 1, ADDR0 = 4'h5, WDATA0 = 8'hA5 from IDLE. Required: GNT0 and RF_WR_EN in cycle t+1, RF_ADDR = 5, RF_WR_DATA = A5; no GNT1; back in IDLE at t+2.
- Simultaneous reads: REQ0 and REQ1 both high, reading addresses 2 and 3, Reg_File model holding 8'h81 / 8'h0D. Required: r0 is granted first (LAST = 1 after reset), RDATA0 = 81 with RVALID0; then r1 is granted, RDATA1 = 0D with RVALID1; grant order is 0, 1, 0, 1 over 4 repeats.
- Timeout: read from r1 with the model never asserting valid, RD_TIMEOUT = 7. Required: ERR1 pulses exactly once, RDATA1 = 0, RVALID1 stays 0, and the arbiter accepts a new REQ0 afterwards.
- Reset during WAIT_RD: assert RST = 0 for one edge, then return RF_RD_VALID. Required: all outputs 0, no RVALID, RF_RD_VALID ignored, LAST = 1.
- Stray valid: RF_RD_VALID pulsed while in IDLE and during a write ISSUE. Required: no RVALID0/RVALID1 and RDATA unchanged.
- Valid/timeout coincidence: RF_RD_VALID arrives on the cycle the counter equals RD_TIMEOUT, data 8'h3C. Required: RVALID with RDATA = 3C and no ERR.
